// File: rtl/player_ship_if.sv
// Player ship bus: keyboard/collision inputs, ship state outputs.
// master drives the inputs, slave is the ship controller.
interface player_ship_if #(
  parameter int W = 10
) ();
  logic [15:0]  keycode;
  logic         collision;
  logic         shot_active;
  logic [W-1:0] SHIPX;
  logic [W-1:0] SHIPY;
  logic         ship;
  logic         exploding;
  logic         fire;
  logic [3:0]   lives;
  logic         game_over;

  modport master (
    output keycode, collision, shot_active,
    input  SHIPX, SHIPY, ship, exploding, fire, lives, game_over
  );

  modport slave (
    input  keycode, collision, shot_active,
    output SHIPX, SHIPY, ship, exploding, fire, lives, game_over
  );
endinterface

// File: rtl/player_ship.sv
// Player ship controller: movement, firing, lives and explosion FSM.
// Option: define PLAYER_SHIP_AUTOFIRE_EN for held-key autofire.
module player_ship #(
  parameter int W              = 10,
  parameter int X_MIN          = 12,
  parameter int X_MAX          = 206,
  parameter int X_START        = 15,
  parameter int Y_POS          = 250,
  parameter int SIZE           = 16,
  parameter int STEP           = 2,
  parameter int LIVES          = 3,
  parameter int EXPLODE_FRAMES = 32,
  parameter int FIRE_COOLDOWN  = 8
) (
  input logic         frame_clk,
  input logic         Reset_n,
  player_ship_if.slave bus
);

  localparam int XHI = X_MAX - SIZE;
  localparam int CDW = $clog2(FIRE_COOLDOWN + 1);
  localparam int ECW = $clog2(EXPLODE_FRAMES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ALIVE,
    EXPLODE,
    GAMEOVER
  } state_t;

  state_t         state;
  logic [W-1:0]   x;
  logic [3:0]     lives_q;
  logic [CDW-1:0] cd;
  logic [ECW-1:0] ecnt;
  logic           fire_q;
  logic           fire_prev;

  logic           k_left;
  logic           k_right;
  logic           k_fire;
  logic           k_start;
  logic           fire_qual;
  logic           fire_ok;
  logic [W-1:0]   move_x;
  int             nx;

  function automatic logic hit(
    input logic [15:0] kc,
    input logic [7:0]  code
  );
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

  assign k_left  = hit(bus.keycode, 8'h04);
  assign k_right = hit(bus.keycode, 8'h07);
  assign k_fire  = hit(bus.keycode, 8'h2C);
  assign k_start = hit(bus.keycode, 8'h28);

`ifdef PLAYER_SHIP_AUTOFIRE_EN
  assign fire_qual = k_fire;
`else
  assign fire_qual = k_fire & ~fire_prev;
`endif

  assign fire_ok = fire_qual & (cd == '0)
                 & ~bus.shot_active & ~bus.collision;

  // Next X from the held direction keys, clamped without wrap
  always_comb begin
    nx = int'(x);
    if (k_left & ~k_right) begin
      nx = nx - STEP;
    end else if (k_right & ~k_left) begin
      nx = nx + STEP;
    end
    if (nx < X_MIN) begin
      nx = X_MIN;
    end else if (nx > XHI) begin
      nx = XHI;
    end
    move_x = W'(nx);
  end

  // Game FSM with position, lives, cooldown and fire registers
  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      x         <= W'(X_START);
      lives_q   <= '0;
      cd        <= '0;
      ecnt      <= '0;
      fire_q    <= 1'b0;
      fire_prev <= 1'b0;
    end else begin
      fire_prev <= k_fire;
      fire_q    <= 1'b0;
      if (cd != '0) begin
        cd <= cd - 1'b1;
      end
      unique case (state)
        IDLE, GAMEOVER: begin
          if (k_start) begin
            state   <= ALIVE;
            lives_q <= 4'(LIVES);
            x       <= W'(X_START);
            cd      <= '0;
          end
        end
        ALIVE: begin
          if (bus.collision) begin
            state   <= EXPLODE;
            lives_q <= lives_q - 1'b1;
            ecnt    <= ECW'(EXPLODE_FRAMES - 1);
          end else begin
            x <= move_x;
            if (fire_ok) begin
              fire_q <= 1'b1;
              cd     <= CDW'(FIRE_COOLDOWN);
            end
          end
        end
        EXPLODE: begin
          if (ecnt == '0) begin
            if (lives_q == '0) begin
              state <= GAMEOVER;
            end else begin
              state <= ALIVE;
              x     <= W'(X_START);
              cd    <= '0;
            end
          end else begin
            ecnt <= ecnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.SHIPX     = x;
  assign bus.SHIPY     = W'(Y_POS);
  assign bus.ship      = (state == ALIVE);
  assign bus.exploding = (state == EXPLODE);
  assign bus.game_over = (state == GAMEOVER);
  assign bus.fire      = fire_q;
  assign bus.lives     = lives_q;

endmodule

// File: tb/tb_player_ship.sv
// Bench for player_ship: directed scenarios plus random play,
// all outputs compared against a frame-level game model.
module tb_player_ship;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   run = 1'b0;

  player_ship_if #(.W(10)) bus ();

  player_ship dut (
    .frame_clk (clk),
    .Reset_n   (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE = 0;
  localparam int M_ALIVE = 1;
  localparam int M_BOOM = 2;
  localparam int M_OVER = 3;

  int m_mode = M_IDLE;
  int m_x = 15;
  int m_lives = 0;
  int m_cd = 0;
  int m_boom = 0;
  int m_fire = 0;
  bit m_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit held(input logic [15:0] kc, input int code);
    return (int'(kc[7:0]) == code) || (int'(kc[15:8]) == code);
  endfunction

  // Game model: one frame of rules applied at each clock edge
  always @(posedge clk) begin
    bit l, r, f, s, q;
    int ncd;
    int nfire;
    if (!rst_n) begin
      m_mode = M_IDLE; m_x = 15; m_lives = 0;
      m_cd = 0; m_boom = 0; m_fire = 0; m_prev = 0;
    end else begin
      l = held(bus.keycode, 'h04);
      r = held(bus.keycode, 'h07);
      f = held(bus.keycode, 'h2C);
      s = held(bus.keycode, 'h28);
`ifdef PLAYER_SHIP_AUTOFIRE_EN
      q = f;
`else
      q = f && !m_prev;
`endif
      ncd = (m_cd > 0) ? m_cd - 1 : 0;
      nfire = 0;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
        if (s) begin
          m_mode = M_ALIVE; m_lives = 3; m_x = 15; ncd = 0;
        end
      end else if (m_mode == M_ALIVE) begin
        if (bus.collision) begin
          m_mode = M_BOOM; m_lives = m_lives - 1; m_boom = 32;
        end else begin
          if (l && !r) m_x = m_x - 2;
          if (r && !l) m_x = m_x + 2;
          if (m_x < 12) m_x = 12;
          if (m_x > 190) m_x = 190;
          if (q && m_cd == 0 && !bus.shot_active) begin
            nfire = 1; ncd = 8;
          end
        end
      end else begin
        m_boom = m_boom - 1;
        if (m_boom == 0) begin
          if (m_lives == 0) m_mode = M_OVER;
          else begin
            m_mode = M_ALIVE; m_x = 15; ncd = 0;
          end
        end
      end
      m_prev = f;
      m_cd = ncd;
      m_fire = nfire;
    end
  end

  // Every-frame comparison of all outputs against the model
  always @(negedge clk) begin
    if (run) begin
      chk("SHIPX", int'(bus.SHIPX), m_x);
      chk("SHIPY", int'(bus.SHIPY), 250);
      chk("ship", int'(bus.ship), int'(m_mode == M_ALIVE));
      chk("exploding", int'(bus.exploding), int'(m_mode == M_BOOM));
      chk("game_over", int'(bus.game_over), int'(m_mode == M_OVER));
      chk("fire", int'(bus.fire), m_fire);
      chk("lives", int'(bus.lives), m_lives);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic keys(input logic [15:0] kc);
    bus.keycode = kc;
  endtask

  initial begin
    int pulses;
    int ecount;
    int exp_pulses;
    logic [7:0] codes [6];
    codes[0] = 8'h00; codes[1] = 8'h04; codes[2] = 8'h07;
    codes[3] = 8'h2C; codes[4] = 8'h28; codes[5] = 8'h00;
`ifdef PLAYER_SHIP_AUTOFIRE_EN
    exp_pulses = 3;
`else
    exp_pulses = 1;
`endif
    bus.keycode = 16'h0;
    bus.collision = 1'b0;
    bus.shot_active = 1'b0;
    run = 1'b1;
    tick(); tick();
    chk("rst_shipx", int'(bus.SHIPX), 15);
    chk("rst_lives", int'(bus.lives), 0);
    chk("rst_ship", int'(bus.ship), 0);
    chk("rst_gameover", int'(bus.game_over), 0);

    rst_n = 1'b1;
    tick();
    keys(16'h0028);
    tick();
    chk("start_ship", int'(bus.ship), 1);
    chk("start_lives", int'(bus.lives), 3);
    chk("start_x", int'(bus.SHIPX), 15);

    keys(16'h0004);
    tick();
    chk("left_13", int'(bus.SHIPX), 13);
    tick();
    chk("left_clamp12", int'(bus.SHIPX), 12);
    tick();
    chk("left_hold12", int'(bus.SHIPX), 12);
    keys(16'h0704);
    tick();
    chk("both_hold", int'(bus.SHIPX), 12);
    keys(16'h0700);
    repeat (88) tick();
    chk("right_188", int'(bus.SHIPX), 188);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("right_clamp190", int'(bus.SHIPX), 190);
    end
    keys(16'h0);
    tick();

    pulses = 0;
    keys(16'h002C);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fire) pulses++;
    end
    chk("fire_pulses", pulses, exp_pulses);
    keys(16'h0);
    tick();

    pulses = 0;
    bus.shot_active = 1'b1;
    keys(16'h2C00);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.fire) pulses++;
    end
    chk("fire_shot_active", pulses, 0);
    bus.shot_active = 1'b0;
    keys(16'h0);
    repeat (10) tick();

    keys(16'h002C);
    bus.collision = 1'b1;
    tick();
    chk("col_fire", int'(bus.fire), 0);
    chk("col_exploding", int'(bus.exploding), 1);
    chk("col_lives", int'(bus.lives), 2);
    keys(16'h0);
    bus.collision = 1'b0;
    ecount = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.exploding) ecount++;
      else break;
    end
    chk("explode_frames", ecount, 32);
    chk("respawn_ship", int'(bus.ship), 1);
    chk("respawn_x", int'(bus.SHIPX), 15);

    for (int n = 0; n < 2; n++) begin
      bus.collision = 1'b1;
      tick();
      bus.collision = 1'b0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (!bus.exploding) break;
      end
    end
    chk("over_flag", int'(bus.game_over), 1);
    chk("over_lives", int'(bus.lives), 0);
    keys(16'h2800);
    tick();
    chk("restart_ship", int'(bus.ship), 1);
    chk("restart_lives", int'(bus.lives), 3);
    keys(16'h0);

    bus.collision = 1'b1;
    tick();
    bus.collision = 1'b0;
    repeat (9) tick();
    chk("mid_explode", int'(bus.exploding), 1);
    rst_n = 1'b0;
    keys(16'h0028);
    tick();
    chk("rst_explode", int'(bus.exploding), 0);
    chk("rst_explode_x", int'(bus.SHIPX), 15);
    chk("rst_explode_ship", int'(bus.ship), 0);
    rst_n = 1'b1;
    keys(16'h0);

    for (int i = 0; i < 4000; i++) begin
      bus.keycode = {codes[$urandom_range(0, 5)],
                     codes[$urandom_range(0, 5)]};
      if ($urandom_range(0, 15) == 0) begin
        bus.keycode[7:0] = 8'($urandom);
      end
      bus.collision = ($urandom_range(0, 9) == 0);
      bus.shot_active = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
